// File: rtl/rvb_bitcnt_pipe_if.sv
// Request/response channel of the pipelined bit-count unit.
// Request: valid/ready with operand, op, word mode and tag. Response: valid/ready with count and tag.
interface rvb_bitcnt_pipe_if #(
  parameter int XLEN = 64,
  parameter int TAGW = 4
);
  logic            din_valid;
  logic            din_ready;
  logic [XLEN-1:0] din_rs1;
  logic [2:0]      din_op;
  logic            din_wmode;
  logic [TAGW-1:0] din_tag;
  logic            dout_valid;
  logic            dout_ready;
  logic [XLEN-1:0] dout_rd;
  logic [TAGW-1:0] dout_tag;

  modport master (
    output din_valid, din_rs1, din_op, din_wmode, din_tag, dout_ready,
    input  din_ready, dout_valid, dout_rd, dout_tag
  );

  modport slave (
    input  din_valid, din_rs1, din_op, din_wmode, din_tag, dout_ready,
    output din_ready, dout_valid, dout_rd, dout_tag
  );
endinterface

// File: rtl/rvb_bitcnt_pipe.sv
// Two-stage CLZ/CTZ/PCNT unit (CLO/CTO when RVB_BITCNT_PIPE_ONES_EN is defined), word and XLEN modes.
// Latency: operand registered into stage 1 on accept, result registered into stage 2 on the next edge; 1 op/cycle.
// Backpressure: result held while dout_ready=0; din_ready drops only with both stages full and the output stalled.
module rvb_bitcnt_pipe #(
  parameter int XLEN = 64,
  parameter int TAGW = 4
) (
  input  logic              clock,
  input  logic              reset,
  rvb_bitcnt_pipe_if.slave  bus
);

  localparam int NB = XLEN / 8;
  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [TAGW-1:0]      tag;
    logic [NB-1:0][3:0]   cnt;
  } s1_t;

  logic            s1_valid;
  logic            s2_valid;
  s1_t             s1_q;
  s1_t             s1_d;
  logic [6:0]      s2_sum;
  logic [6:0]      sum_d;
  logic [TAGW-1:0] s2_tag;
  logic            s2_load;
  logic            s1_adv;
  logic            accept;

  assign s2_load       = !s2_valid || bus.dout_ready;
  assign s1_adv        = s1_valid && s2_load;
  assign bus.din_ready = !reset && (!s1_valid || s2_load);
  assign accept        = bus.din_valid && bus.din_ready;

  logic            wide;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] x_in;
  logic [XLEN-1:0] x_rev_full;
  logic [XLEN-1:0] x_rev32;
  logic [XLEN-1:0] x_sel;
  logic [XLEN-1:0] x_src;
  logic [XLEN-1:0] x_tz;
  logic [XLEN-1:0] x_pre;
  logic            do_rev;
  logic            is_tz;
  logic            is_pc;
  logic [3:0]      bcnt;
`ifdef RVB_BITCNT_PIPE_ONES_EN
  logic            do_inv;
`endif

  // Stage 1 preprocessing: every count-leading/trailing op is reduced to a
  // trailing-zero count, which (x-1) & ~x turns into a popcount.
  always_comb begin
    wide   = (XLEN > 32) && !bus.din_wmode;
    w_mask = '0;
    w_mask[31:0] = '1;
    if (wide) w_mask = '1;
    x_in = bus.din_rs1 & w_mask;

    x_rev_full = '0;
    for (int i = 0; i < XLEN; i++) x_rev_full[i] = x_in[XLEN-1-i];
    x_rev32 = '0;
    for (int i = 0; i < 32; i++) x_rev32[i] = x_in[31-i];

    do_rev = 1'b0;
    is_tz  = 1'b0;
    is_pc  = 1'b0;
`ifdef RVB_BITCNT_PIPE_ONES_EN
    do_inv = 1'b0;
`endif
    case (bus.din_op)
      3'b000: begin do_rev = 1'b1; is_tz = 1'b1; end
      3'b001: is_tz = 1'b1;
      3'b010: is_pc = 1'b1;
`ifdef RVB_BITCNT_PIPE_ONES_EN
      3'b100: begin do_rev = 1'b1; do_inv = 1'b1; is_tz = 1'b1; end
      3'b101: begin do_inv = 1'b1; is_tz = 1'b1; end
`endif
      default: ;
    endcase

    x_sel = do_rev ? (wide ? x_rev_full : x_rev32) : x_in;
`ifdef RVB_BITCNT_PIPE_ONES_EN
    x_src = do_inv ? (~x_sel & w_mask) : x_sel;
`else
    x_src = x_sel;
`endif
    x_tz  = ((x_src - ONE) & ~x_src) & w_mask;
    x_pre = is_tz ? x_tz : (is_pc ? x_in : '0);

    s1_d     = '0;
    s1_d.tag = bus.din_tag;
    bcnt     = '0;
    for (int b = 0; b < NB; b++) begin
      bcnt = '0;
      for (int k = 0; k < 8; k++) bcnt = bcnt + {3'b000, x_pre[8*b+k]};
      s1_d.cnt[b] = bcnt;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int b = 0; b < NB; b++) sum_d = sum_d + {3'b000, s1_q.cnt[b]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_sum   <= '0;
      s2_tag   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_q     <= s1_d;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) s2_valid <= s1_valid;
      if (s1_adv) begin
        s2_sum <= sum_d;
        s2_tag <= s1_q.tag;
      end
    end
  end

  assign bus.dout_valid = s2_valid;
  assign bus.dout_rd    = {{(XLEN-7){1'b0}}, s2_sum};
  assign bus.dout_tag   = s2_tag;

endmodule

// File: tb/tb_rvb_bitcnt_pipe.sv
// Directed bench for rvb_bitcnt_pipe at XLEN=64, TAGW=4: counts, word mode, backpressure,
// back-to-back streaming, asynchronous reset with ops in flight, and the optional CLO/CTO ops.
module tb_rvb_bitcnt_pipe;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  rvb_bitcnt_pipe_if #(.XLEN(64), .TAGW(4)) bif ();

  rvb_bitcnt_pipe #(.XLEN(64), .TAGW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic wm, input logic [63:0] rs1, input logic [3:0] tag);
    bif.din_valid = 1'b1;
    bif.din_op    = op;
    bif.din_wmode = wm;
    bif.din_rs1   = rs1;
    bif.din_tag   = tag;
  endtask

  task automatic run_one(input string name, input logic [2:0] op, input logic wm,
                         input logic [63:0] rs1, input logic [3:0] tag, input logic [63:0] exp);
    bif.dout_ready = 1'b1;
    drive(op, wm, rs1, tag);
    step();
    bif.din_valid = 1'b0;
    chk({name, "_early"}, bif.dout_valid, 1'b0);
    step();
    chk({name, "_valid"}, bif.dout_valid, 1'b1);
    chk({name, "_rd"},    bif.dout_rd,    exp);
    chk({name, "_tag"},   bif.dout_tag,   tag);
    step();
  endtask

  logic [2:0]  s_op  [7];
  logic        s_wm  [7];
  logic [63:0] s_rs1 [7];
  logic [3:0]  s_tag [7];
  logic [63:0] s_exp [7];
  logic [63:0] held_rd;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bif.din_valid  = 1'b0;
    bif.din_rs1    = '0;
    bif.din_op     = '0;
    bif.din_wmode  = 1'b0;
    bif.din_tag    = '0;
    bif.dout_ready = 1'b0;

    // reset state
    step();
    step();
    chk("rst_din_ready",  bif.din_ready,  1'b0);
    chk("rst_dout_valid", bif.dout_valid, 1'b0);
    chk("rst_dout_rd",    bif.dout_rd,    64'd0);
    chk("rst_dout_tag",   bif.dout_tag,   4'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_din_ready", bif.din_ready, 1'b1);

    // directed counts
    run_one("clz_bit32",    3'b000, 1'b0, 64'h0000_0001_0000_0000, 4'd1, 64'd31);
    run_one("clz_zero",     3'b000, 1'b0, 64'h0,                   4'd2, 64'd64);
    run_one("ctz_w_upper",  3'b001, 1'b1, 64'hFFFF_FFFF_0000_0000, 4'd3, 64'd32);
    run_one("pcnt_ones",    3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 64'd64);
    run_one("pcnt_w",       3'b010, 1'b1, 64'h1234_5678_0000_00FF, 4'd5, 64'd8);
    run_one("pcnt_full",    3'b010, 1'b0, 64'h1234_5678_0000_00FF, 4'd6, 64'd21);
    run_one("ctz_msb",      3'b001, 1'b0, 64'h8000_0000_0000_0000, 4'd7, 64'd63);
    run_one("clz_w_bit16",  3'b000, 1'b1, 64'h0000_0000_0001_0000, 4'd8, 64'd15);
    run_one("clz_w_upper",  3'b000, 1'b1, 64'hFFFF_FFFF_0000_0000, 4'd9, 64'd32);
    run_one("rsv_110",      3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 64'd0);
`ifdef RVB_BITCNT_PIPE_ONES_EN
    run_one("clo_top_byte", 3'b100, 1'b0, 64'hFF00_0000_0000_0000, 4'd11, 64'd8);
    run_one("cto_w_ones",   3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 4'd12, 64'd32);
    run_one("clo_w_zero",   3'b100, 1'b1, 64'hFFFF_FFFF_0000_0000, 4'd13, 64'd0);
`else
    run_one("clo_top_byte", 3'b100, 1'b0, 64'hFF00_0000_0000_0000, 4'd11, 64'd0);
    run_one("cto_w_ones",   3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 4'd12, 64'd0);
`endif

    // backpressure: 4 ops, output stalled for 3 cycles after the first accept
    bif.dout_ready = 1'b0;
    drive(3'b010, 1'b0, 64'h1, 4'd1);
    #1;
    chk("bp_rdy0", bif.din_ready, 1'b1);
    step();
    drive(3'b010, 1'b0, 64'h3, 4'd2);
    chk("bp_rdy1", bif.din_ready, 1'b1);
    step();
    chk("bp_rdy_drop", bif.din_ready,  1'b0);
    chk("bp_v_t1",     bif.dout_valid, 1'b1);
    chk("bp_tag_t1",   bif.dout_tag,   4'd1);
    chk("bp_rd_t1",    bif.dout_rd,    64'd1);
    held_rd = bif.dout_rd;
    drive(3'b010, 1'b0, 64'h7, 4'd3);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("bp_hold_rdy", bif.din_ready, 1'b0);
      chk("bp_hold_tag", bif.dout_tag,  4'd1);
      chk("bp_hold_rd",  bif.dout_rd,   held_rd);
    end
    bif.dout_ready = 1'b1;
    #1;
    chk("bp_release_rdy", bif.din_ready, 1'b1);
    step();
    drive(3'b010, 1'b0, 64'hF, 4'd4);
    chk("bp_v_t2",   bif.dout_valid, 1'b1);
    chk("bp_tag_t2", bif.dout_tag,   4'd2);
    chk("bp_rd_t2",  bif.dout_rd,    64'd2);
    step();
    bif.din_valid = 1'b0;
    chk("bp_v_t3",   bif.dout_valid, 1'b1);
    chk("bp_tag_t3", bif.dout_tag,   4'd3);
    chk("bp_rd_t3",  bif.dout_rd,    64'd3);
    step();
    chk("bp_v_t4",   bif.dout_valid, 1'b1);
    chk("bp_tag_t4", bif.dout_tag,   4'd4);
    chk("bp_rd_t4",  bif.dout_rd,    64'd4);
    step();
    chk("bp_empty",  bif.dout_valid, 1'b0);

    // back-to-back stream, one result per cycle
    s_op[0] = 3'b010; s_wm[0] = 1'b0; s_rs1[0] = 64'hFF;                  s_tag[0] = 4'h5; s_exp[0] = 64'd8;
    s_op[1] = 3'b011; s_wm[1] = 1'b0; s_rs1[1] = 64'hFFFF;                s_tag[1] = 4'hA; s_exp[1] = 64'd0;
    s_op[2] = 3'b000; s_wm[2] = 1'b1; s_rs1[2] = 64'h8000_0000;           s_tag[2] = 4'hB; s_exp[2] = 64'd0;
    s_op[3] = 3'b001; s_wm[3] = 1'b0; s_rs1[3] = 64'h0;                   s_tag[3] = 4'hC; s_exp[3] = 64'd64;
    s_op[4] = 3'b000; s_wm[4] = 1'b0; s_rs1[4] = 64'hFFFF_FFFF_FFFF_FFFF; s_tag[4] = 4'hD; s_exp[4] = 64'd0;
    s_op[5] = 3'b111; s_wm[5] = 1'b0; s_rs1[5] = 64'hFFFF_FFFF_FFFF_FFFF; s_tag[5] = 4'hE; s_exp[5] = 64'd0;
    s_op[6] = 3'b001; s_wm[6] = 1'b1; s_rs1[6] = 64'h100;                 s_tag[6] = 4'hF; s_exp[6] = 64'd8;
    bif.dout_ready = 1'b1;
    drive(s_op[0], s_wm[0], s_rs1[0], s_tag[0]);
    step();
    for (int i = 1; i <= 7; i++) begin
      if (i < 7) drive(s_op[i], s_wm[i], s_rs1[i], s_tag[i]);
      else bif.din_valid = 1'b0;
      step();
      chk("str_valid", bif.dout_valid, 1'b1);
      chk("str_rd",    bif.dout_rd,    s_exp[i-1]);
      chk("str_tag",   bif.dout_tag,   s_tag[i-1]);
    end
    step();
    chk("str_drained", bif.dout_valid, 1'b0);

    // asynchronous reset with two ops in flight
    bif.dout_ready = 1'b0;
    drive(3'b010, 1'b0, 64'hFFFF, 4'd6);
    step();
    drive(3'b010, 1'b0, 64'hFF, 4'd7);
    step();
    bif.din_valid = 1'b0;
    chk("ar_pre_valid", bif.dout_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", bif.dout_valid, 1'b0);
    chk("ar_rd",    bif.dout_rd,    64'd0);
    chk("ar_tag",   bif.dout_tag,   4'd0);
    chk("ar_rdy",   bif.din_ready,  1'b0);
    step();
    reset = 1'b0;
    bif.dout_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("ar_no_stale", bif.dout_valid, 1'b0);
    end
    run_one("ar_after", 3'b001, 1'b0, 64'h10, 4'd9, 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvb_bitcnt_pipe.md
Name: rvb_bitcnt_pipe

Overview:
- Two-stage pipelined bit-count unit for the bitmanip extension: CLZ, CTZ and PCNT in word (32-bit) and XLEN modes.
- Full valid/ready flow control with backpressure, plus a sideband tag carried alongside each result.
- Successor to the single-cycle combinational counter, for cores whose cycle time cannot absorb a 64-bit popcount tree.
- Sits between the bitmanip decode stage and the writeback arbiter.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64; XLEN==32 forces word mode.
TAGW, 4, width of the sideband tag carried with each operation (>=1).

Ports:
clock  input  1  positive-edge clock
reset  input  1  asynchronous reset, active-high
din_valid  input  1  operation offered
din_ready  output  1  unit accepts the operation this cycle
din_rs1  input  XLEN  operand
din_op  input  3  000 CLZ, 001 CTZ, 010 PCNT, 100 CLO, 101 CTO; all others reserved
din_wmode  input  1  1 = operate on rs1[31:0] only
din_tag  input  TAGW  sideband tag, returned unchanged with the result
dout_valid  output  1  result available
dout_ready  input  1  consumer accepts the result
dout_rd  output  XLEN  count, zero-extended
dout_tag  output  TAGW  tag of the result

Behaviour:
- Reset (asynchronous, active-high): s1_valid=0, s2_valid=0, dout_rd=0, dout_tag=0, din_ready=0 while reset is high. All in-flight operations are discarded. The first accept is possible on the first clock edge after reset deasserts.
- Word mode: effective width W=32 when din_wmode=1 or XLEN==32, otherwise W=XLEN. Bits above W are ignored.
- Stage 1, preprocessing:
  - x = rs1[W-1:0].
  - CLZ/CLO: bit-reverse x within W.
  - CLO/CTO: invert x within W.
  - CLZ/CTZ/CLO/CTO: x = (x-1) & ~x, computed in W bits.
  - PCNT: x unchanged.
  - Reserved ops: x = 0, giving a result of 0.
- Stage 1, register: 4-bit popcount of each byte of x, XLEN/8 fields, plus the tag.
- Stage 2: sum of the byte counts, 7 bits, zero-extended into dout_rd; tag moves to dout_tag. Both are registered.
- Result ranges:
  - All-zero operand: CLZ = CTZ = W.
  - All-ones operand in W: PCNT = W; CLO = CTO = W.
- Latency: exactly 2 cycles from the accept edge to dout_valid=1 when unstalled. Throughput 1 op/cycle.
- Handshake:
  - s2_load = !s2_valid || dout_ready.
  - s1_adv = s1_valid && s2_load.
  - din_ready = !reset && (!s1_valid || s2_load).
  - Accept = din_valid && din_ready.
  - dout_valid = s2_valid.
- Backpressure:
  - While dout_valid && !dout_ready, dout_rd and dout_tag hold stable.
  - The pipe holds at most 2 ops; din_ready falls only when both stages are full and dout_ready=0.
- Simultaneous events:
  - Accept and s1 advance in the same cycle: s1 reloads.
  - Output consumed and s1 advances into s2 in the same cycle: no bubble.
  - Ordering is strictly FIFO.
- din_* is sampled only on accept. Changes while din_ready=0 are ignored.
- No combinational path from din_valid to din_ready. dout_ready reaches din_ready through a single gate level only.

Optional Feature:
- Macro: RVB_BITCNT_PIPE_ONES_EN.
- Defined: ops 100 (CLO) and 101 (CTO) are supported as above.
- Undefined: ops 100 and 101 are treated as reserved (result 0), and the inversion logic is not built.
- All other behaviour is identical in both builds.

Test Plan:
- XLEN=64, CLZ, wmode=0, rs1=0x0000_0001_0000_0000 -> dout_rd=31, 2 cycles after accept; same op with rs1=0 -> 64.
- CTZ, wmode=1, rs1=0xFFFF_FFFF_0000_0000 -> 32 (upper bits ignored); PCNT, wmode=0, rs1=all ones -> 64; PCNT, wmode=1, rs1=0x1234_5678_0000_00FF -> 8.
- Stream 4 ops with tags 1..4, dout_ready=0 for 3 cycles after the first accept:
  - din_ready drops after 2 accepts.
  - dout_rd/dout_tag stay stable for tag 1.
  - On release, results arrive with tags 1,2,3,4 in order, with no gaps while dout_ready=1.
- Continuous valid input with dout_ready=1 -> one result per cycle; reserved op 011 -> 0 with its tag preserved.
- Assert reset asynchronously between edges with 2 ops in flight:
  - dout_valid, dout_rd and dout_tag go to 0 immediately.
  - No stale result appears after reset deasserts.
- With RVB_BITCNT_PIPE_ONES_EN defined:
  - CLO, rs1=0xFF00_0000_0000_0000 -> 8.
  - CTO, wmode=1, rs1=0x0000_0000_FFFF_FFFF -> 32.
  - Without the macro, both ops -> 0.
